player_looper: RTL and testbench

- Sequencer on the playback clock, sitting directly downstream of the sample player.
- Drives the player's active-low restart, consumes its sample word and done flag, and replays the buffer a programmed number of times (or forever).
- Produces a registered, polarity-adjusted output word, with a defined idle value whenever no playback is in progress.

---
 rtl/player_looper.sv | 121 ++++++++++++
 tb/tb_player_looper.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/player_looper.sv
// player_looper: sequences the sample player on the playback clock.
// Holds the player in restart while idle, releases it on start, and on each
// done either re-arms the player for another pass (one restart cycle) or
// returns to idle once the programmed number of passes has completed.
// loops == 0 at the start edge means replay until stop or reset.
// Every output is a register; out carries idle_value whenever nothing plays.
module player_looper #(
    parameter int outputBits = 32,
    parameter int loopBits   = 16
) (
    input  logic                  r_clk,
    input  logic                  r_reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [loopBits-1:0]   loops,
    input  logic [outputBits-1:0] idle_value,
    input  logic [outputBits-1:0] invert,
    output logic                  p_reset_n,
    input  logic [outputBits-1:0] p_out,
    input  logic                  p_done,
    output logic [outputBits-1:0] out,
    output logic                  active,
    output logic [loopBits-1:0]   loop_count,
    output logic                  finished
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAY    = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [loopBits-1:0]     loops_l_q, loops_l_d;
    logic [loopBits-1:0]     loop_count_q, loop_count_d;
    logic [loopBits-1:0]     pass_n;
    logic                    finished_q, finished_d;
    logic                    p_reset_n_q, p_reset_n_d;
    logic                    active_q, active_d;
    logic [outputBits-1:0]   out_q, out_d;

    // Next-state, pass counting and registered-output decode.
    always_comb begin
        state_d      = state_q;
        loops_l_d    = loops_l_q;
        loop_count_d = loop_count_q;
        finished_d   = 1'b0;
        // Pass number that a done in PLAY would complete; wraps naturally.
        pass_n       = loop_count_q + loopBits'(1);

        case (state_q)
            ST_IDLE: begin
                // stop beats a simultaneous start.
                if (start && !stop) begin
                    state_d      = ST_PLAY;
                    loops_l_d    = loops;
                    loop_count_d = '0;
                end
            end
            ST_PLAY: begin
                // stop beats a simultaneous done: no finished pulse.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (p_done) begin
                    loop_count_d = pass_n;
                    if ((loops_l_q != '0) && (pass_n == loops_l_q)) begin
                        state_d    = ST_IDLE;
                        finished_d = 1'b1;
                    end else begin
                        state_d = ST_RESTART;
                    end
                end
            end
            ST_RESTART: begin
                // One cycle of player reset so p_done is clear on PLAY entry.
                if (stop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the state being entered, so they line
        // up with the state register after the edge.
        p_reset_n_d = (state_d == ST_PLAY);
        active_d    = (state_d != ST_IDLE);
        out_d       = active_d ? (p_out ^ invert) : idle_value;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            state_q      <= ST_IDLE;
            loops_l_q    <= '0;
            loop_count_q <= '0;
            finished_q   <= 1'b0;
            p_reset_n_q  <= 1'b0;
            active_q     <= 1'b0;
            out_q        <= '0;
        end else begin
            state_q      <= state_d;
            loops_l_q    <= loops_l_d;
            loop_count_q <= loop_count_d;
            finished_q   <= finished_d;
            p_reset_n_q  <= p_reset_n_d;
            active_q     <= active_d;
            out_q        <= out_d;
        end
    end

    assign p_reset_n  = p_reset_n_q;
    assign active     = active_q;
    assign out        = out_q;
    assign loop_count = loop_count_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_player_looper.sv
// Bench for player_looper: two instances (16-bit and 2-bit loop counters)
// each driving its own 4-word player model {1,2,3,4}; a pass-level reference
// model predicts every output every cycle, plus a constant vector table and
// directed multi-cycle sequences.
module tb_player_looper;

    logic        r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    logic        r_reset_n, start, stop;
    logic [15:0] loops;
    logic [31:0] idle_value, invert;

    logic        prn0, prn1, pdone0, pdone1, act0, act1, fin0, fin1;
    logic [31:0] pout0, pout1, out0, out1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    player_looper #(.outputBits(32), .loopBits(16)) u_dut0 (
        .r_clk(r_clk), .r_reset_n(r_reset_n), .start(start), .stop(stop),
        .loops(loops), .idle_value(idle_value), .invert(invert),
        .p_reset_n(prn0), .p_out(pout0), .p_done(pdone0), .out(out0),
        .active(act0), .loop_count(cnt0), .finished(fin0)
    );

    player_looper #(.outputBits(32), .loopBits(2)) u_dut1 (
        .r_clk(r_clk), .r_reset_n(r_reset_n), .start(start), .stop(stop),
        .loops(loops[1:0]), .idle_value(idle_value), .invert(invert),
        .p_reset_n(prn1), .p_out(pout1), .p_done(pdone1), .out(out1),
        .active(act1), .loop_count(cnt1), .finished(fin1)
    );

    int checks = 0;
    int errors = 0;

    // player models
    int          pl_idx [2];
    bit          pl_done[2];
    logic [31:0] pbuf   [4];

    // reference model: is a pass being played, is the player being re-armed
    bit          m_play [2];
    bit          m_rst  [2];
    bit          m_fin  [2];
    int          m_loops[2];
    int          m_cnt  [2];
    logic [31:0] m_out  [2];
    int          mod_k  [2];

    int fin_seen;
    int restart_lows;

    typedef struct {
        logic        st;
        logic        sp;
        logic [15:0] lp;
        logic [31:0] e_out;
        logic        e_prn;
        logic        e_act;
        logic        e_fin;
        logic [15:0] e_cnt;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_tick(input int k, input logic pd, input logic [31:0] po);
        int pass;
        if (!r_reset_n) begin
            m_play[k] = 0; m_rst[k] = 0; m_fin[k] = 0;
            m_loops[k] = 0; m_cnt[k] = 0; m_out[k] = 32'h0;
        end else begin
            m_fin[k] = 0;
            if (!(m_play[k] || m_rst[k])) begin
                if (start && !stop) begin
                    m_play[k]  = 1;
                    m_loops[k] = int'(loops) % mod_k[k];
                    m_cnt[k]   = 0;
                end
            end else if (stop) begin
                m_play[k] = 0; m_rst[k] = 0;
            end else if (m_rst[k]) begin
                m_rst[k] = 0; m_play[k] = 1;
            end else if (pd) begin
                pass = (m_cnt[k] + 1) % mod_k[k];
                m_cnt[k]  = pass;
                m_play[k] = 0;
                if (m_loops[k] != 0 && pass == m_loops[k]) m_fin[k] = 1;
                else m_rst[k] = 1;
            end
            m_out[k] = (m_play[k] || m_rst[k]) ? (po ^ invert) : idle_value;
        end
    endtask

    task automatic player_tick(input int k, input logic prn_before);
        if (!prn_before) begin
            pl_idx[k] = 0; pl_done[k] = 0;
        end else if (pl_idx[k] < 3) begin
            pl_idx[k]++;
        end else begin
            pl_done[k] = 1;
        end
    endtask

    // one clock: predict, clock, update players, compare both instances
    task automatic step();
        logic s0, s1;
        s0 = prn0;
        s1 = prn1;
        model_tick(0, pdone0, pout0);
        model_tick(1, pdone1, pout1);
        @(posedge r_clk);
        #1;
        player_tick(0, s0);
        player_tick(1, s1);
        pout0 = pbuf[pl_idx[0]]; pdone0 = pl_done[0];
        pout1 = pbuf[pl_idx[1]]; pdone1 = pl_done[1];
        check("u0 out", out0, m_out[0]);
        check("u0 p_reset_n", 32'(prn0), 32'(m_play[0]));
        check("u0 active", 32'(act0), 32'(m_play[0] | m_rst[0]));
        check("u0 finished", 32'(fin0), 32'(m_fin[0]));
        check("u0 loop_count", 32'(cnt0), 32'(m_cnt[0]));
        check("u1 out", out1, m_out[1]);
        check("u1 p_reset_n", 32'(prn1), 32'(m_play[1]));
        check("u1 active", 32'(act1), 32'(m_play[1] | m_rst[1]));
        check("u1 finished", 32'(fin1), 32'(m_fin[1]));
        check("u1 loop_count", 32'(cnt1), 32'(m_cnt[1]));
        if (fin0) fin_seen++;
        if (act0 && !prn0) restart_lows++;
    endtask

    initial begin
        int n;
        logic [1:0] prev1;
        int hist[$];
        int exp_hist[5];
        bit found;

        pbuf[0] = 32'd1; pbuf[1] = 32'd2; pbuf[2] = 32'd3; pbuf[3] = 32'd4;
        mod_k[0] = 65536; mod_k[1] = 4;
        for (int k = 0; k < 2; k++) begin
            pl_idx[k] = 0; pl_done[k] = 1;
            m_play[k] = 0; m_rst[k] = 0; m_fin[k] = 0;
            m_loops[k] = 0; m_cnt[k] = 0; m_out[k] = 32'h0;
        end
        pout0 = 32'd1; pout1 = 32'd1; pdone0 = 1'b1; pdone1 = 1'b1;

        // vector table: loops=1 run straight after reset, then start+stop in idle
        tbl[0] = '{1'b1, 1'b0, 16'd1, 32'd1,          1'b1, 1'b1, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 16'd0, 32'd1,          1'b1, 1'b1, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b0, 16'd0, 32'd2,          1'b1, 1'b1, 1'b0, 16'd0};
        tbl[3] = '{1'b0, 1'b0, 16'd0, 32'd3,          1'b1, 1'b1, 1'b0, 16'd0};
        tbl[4] = '{1'b0, 1'b0, 16'd0, 32'd4,          1'b1, 1'b1, 1'b0, 16'd0};
        tbl[5] = '{1'b0, 1'b0, 16'd0, 32'hFFFF0000,   1'b0, 1'b0, 1'b1, 16'd1};
        tbl[6] = '{1'b0, 1'b0, 16'd0, 32'hFFFF0000,   1'b0, 1'b0, 1'b0, 16'd1};
        tbl[7] = '{1'b1, 1'b1, 16'd1, 32'hFFFF0000,   1'b0, 1'b0, 1'b0, 16'd1};

        r_reset_n = 1'b0; start = 1'b0; stop = 1'b0; loops = 16'd0;
        idle_value = 32'hFFFF0000; invert = 32'h0;
        fin_seen = 0; restart_lows = 0;

        // reset held 3 cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("reset out", out0, 32'h0);
            check("reset p_reset_n", 32'(prn0), 32'h0);
            check("reset active", 32'(act0), 32'h0);
            check("reset finished", 32'(fin0), 32'h0);
        end
        r_reset_n = 1'b1;
        step();
        check("idle out after release", out0, 32'hFFFF0000);

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            start = tbl[i].st; stop = tbl[i].sp; loops = tbl[i].lp;
            step();
            $display("vec %0d: out=0x%0h prn=%0b act=%0b fin=%0b cnt=%0d", i, out0, prn0, act0, fin0, cnt0);
            check($sformatf("vec%0d out", i), out0, tbl[i].e_out);
            check($sformatf("vec%0d p_reset_n", i), 32'(prn0), 32'(tbl[i].e_prn));
            check($sformatf("vec%0d active", i), 32'(act0), 32'(tbl[i].e_act));
            check($sformatf("vec%0d finished", i), 32'(fin0), 32'(tbl[i].e_fin));
            check($sformatf("vec%0d loop_count", i), 32'(cnt0), 32'(tbl[i].e_cnt));
        end
        start = 1'b0; stop = 1'b0;

        // loops=3 with inversion: two restart lows, one finished pulse
        loops = 16'd3; invert = 32'h0000000F;
        start = 1'b1; step(); start = 1'b0;
        fin_seen = 0; restart_lows = 0;
        n = 0;
        while (act0 && n < 80) begin step(); n++; end
        $display("seq loops=3: cnt=%0d restarts=%0d finished=%0d", cnt0, restart_lows, fin_seen);
        check("loops3 ended", 32'(act0), 32'h0);
        check("loops3 restart lows", 32'(restart_lows), 32'd2);
        check("loops3 finished pulses", 32'(fin_seen), 32'd1);
        check("loops3 loop_count", 32'(cnt0), 32'd3);
        invert = 32'h0;

        // infinite mode, 5 passes, mid-run start, then stop
        loops = 16'd0;
        start = 1'b1; step(); start = 1'b0;
        fin_seen = 0;
        prev1 = cnt1;
        n = 0;
        while (cnt0 != 16'd5 && n < 200) begin
            start = (n == 12);
            step();
            if (cnt1 != prev1) begin hist.push_back(int'(cnt1)); prev1 = cnt1; end
            n++;
        end
        start = 1'b0;
        stop = 1'b1; step(); stop = 1'b0;
        $display("seq infinite: cnt0=%0d cnt1=%0d active=%0b finished=%0d", cnt0, cnt1, act0, fin_seen);
        check("inf active after stop", 32'(act0), 32'h0);
        check("inf loop_count", 32'(cnt0), 32'd5);
        check("inf finished pulses", 32'(fin_seen), 32'd0);
        exp_hist[0] = 1; exp_hist[1] = 2; exp_hist[2] = 3; exp_hist[3] = 0; exp_hist[4] = 1;
        check("2bit history length", 32'(hist.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < hist.size()) check($sformatf("2bit history %0d", i), 32'(hist[i]), 32'(exp_hist[i]));
        end

        // stop coincident with the final done (loops=2)
        loops = 16'd2;
        start = 1'b1; step(); start = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 100) begin
            step();
            found = (cnt0 == 16'd1) && prn0 && pdone0;
            n++;
        end
        check("stop+done reached", 32'(found), 32'h1);
        stop = 1'b1; step(); stop = 1'b0;
        $display("seq stop+done: active=%0b fin=%0b cnt=%0d", act0, fin0, cnt0);
        check("stop+done active", 32'(act0), 32'h0);
        check("stop+done finished", 32'(fin0), 32'h0);
        check("stop+done loop_count", 32'(cnt0), 32'd1);

        // reset in the middle of PLAY
        loops = 16'd0;
        start = 1'b1; step(); start = 1'b0;
        step(); step(); step();
        r_reset_n = 1'b0; step();
        $display("seq mid reset: out=0x%0h cnt=%0d active=%0b", out0, cnt0, act0);
        check("midreset out", out0, 32'h0);
        check("midreset loop_count", 32'(cnt0), 32'h0);
        check("midreset active", 32'(act0), 32'h0);
        check("midreset p_reset_n", 32'(prn0), 32'h0);
        r_reset_n = 1'b1; step();

        // randomized stimulus against the reference model
        for (int i = 0; i < 2000; i++) begin
            start      = ($urandom_range(0, 15) == 0);
            stop       = ($urandom_range(0, 59) == 0);
            loops      = 16'($urandom_range(0, 5));
            idle_value = $urandom;
            if ($urandom_range(0, 7) == 0) invert = $urandom;
            r_reset_n  = ($urandom_range(0, 399) != 0);
            step();
        end
        $display("random phase done: %0d checks so far", checks);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
